// File: rtl/pc_unit.sv
// Program counter: sequential fetch, prioritised jump/branch redirects, and
// one pending redirect held across stalls.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             pc_valid,
  output logic             redirect,
  output logic             misalign_err,
  output logic             wrap
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             redirect_q, redirect_d;
  logic             misalign_q, misalign_d;
  logic             wrap_q, wrap_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_jump_q, pend_jump_d;
  logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic             pend_mis_q, pend_mis_d;

  logic [WIDTH:0]   seq_sum;
  logic             jump_mis;
  logic             branch_mis;

  // Carry out of the WIDTH+1 bit sum marks the wrap to zero.
  assign seq_sum    = {1'b0, pc_q} + {1'b0, STEP_W};
  assign jump_mis   = |(jump_target & ~ALIGN_MASK);
  assign branch_mis = |(branch_target & ~ALIGN_MASK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VECTOR;
      valid_q      <= 1'b0;
      redirect_q   <= 1'b0;
      misalign_q   <= 1'b0;
      wrap_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_jump_q  <= 1'b0;
      pend_addr_q  <= '0;
      pend_mis_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      redirect_q   <= redirect_d;
      misalign_q   <= misalign_d;
      wrap_q       <= wrap_d;
      pend_valid_q <= pend_valid_d;
      pend_jump_q  <= pend_jump_d;
      pend_addr_q  <= pend_addr_d;
      pend_mis_q   <= pend_mis_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    redirect_d   = 1'b0;
    misalign_d   = 1'b0;
    wrap_d       = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_jump_d  = pend_jump_q;
    pend_addr_d  = pend_addr_q;
    pend_mis_d   = pend_mis_q;

    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        valid_d = 1'b1;
      end
      ST_RUN: begin
        valid_d = 1'b1;
        if (stall) begin
          // A queued jump can only be displaced by another jump.
          if (jump) begin
            pend_valid_d = 1'b1;
            pend_jump_d  = 1'b1;
            pend_addr_d  = jump_target & ALIGN_MASK;
            pend_mis_d   = jump_mis;
          end else if (branch_taken && !(pend_valid_q && pend_jump_q)) begin
            pend_valid_d = 1'b1;
            pend_jump_d  = 1'b0;
            pend_addr_d  = branch_target & ALIGN_MASK;
            pend_mis_d   = branch_mis;
          end
        end else begin
          pend_valid_d = 1'b0;
          pend_jump_d  = 1'b0;
          if (jump) begin
            pc_d       = jump_target & ALIGN_MASK;
            redirect_d = 1'b1;
            misalign_d = jump_mis;
          end else if (pend_valid_q) begin
            pc_d       = pend_addr_q;
            redirect_d = 1'b1;
            misalign_d = pend_mis_q;
          end else if (branch_taken) begin
            pc_d       = branch_target & ALIGN_MASK;
            redirect_d = 1'b1;
            misalign_d = branch_mis;
          end else begin
            pc_d   = seq_sum[WIDTH-1:0];
            wrap_d = seq_sum[WIDTH];
          end
        end
      end
    endcase
  end

  assign pc           = pc_q;
  assign pc_next_seq  = seq_sum[WIDTH-1:0];
  assign pc_valid     = valid_q;
  assign redirect     = redirect_q;
  assign misalign_err = misalign_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, hand sequences for reset and the
// 16-bit wrap, then randomized traffic against an arithmetic reference model.
module tb_pc_unit;

  localparam longint unsigned MOD  = 64'h1_0000_0000;
  localparam longint unsigned STEP = 4;

  logic        clk, rst;
  logic        stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_next_seq;
  logic        pc_valid, redirect, misalign_err, wrap;

  logic        s16, b16, j16;
  logic [15:0] bt16, jt16, pc16, nseq16;
  logic        pv16, red16, mis16, wrap16;

  int checks   = 0;
  int failures = 0;

  pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .pc(pc), .pc_next_seq(pc_next_seq), .pc_valid(pc_valid),
    .redirect(redirect), .misalign_err(misalign_err), .wrap(wrap)
  );

  pc_unit #(.WIDTH(16), .STEP(2), .RESET_VECTOR(16'h0)) dut16 (
    .clk(clk), .rst(rst), .stall(s16),
    .branch_taken(b16), .branch_target(bt16),
    .jump(j16), .jump_target(jt16),
    .pc(pc16), .pc_next_seq(nseq16), .pc_valid(pv16),
    .redirect(red16), .misalign_err(mis16), .wrap(wrap16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state: raw pending address plus a numeric priority.
  bit              m_run, m_pv, m_red, m_mis, m_wrap;
  int              m_pprio;
  longint unsigned m_pc, m_paddr;

  function automatic longint unsigned align(input longint unsigned a);
    return a - (a % STEP);
  endfunction

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_pprio = 0; m_paddr = 0;
    m_pc = 0; m_red = 0; m_mis = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit s, input bit j, input longint unsigned jt,
                            input bit b, input longint unsigned bt);
    int              prio;
    longint unsigned tgt;
    bit              take;
    m_red = 0; m_mis = 0; m_wrap = 0;
    if (!m_run) begin
      m_run = 1;
      return;
    end
    prio = j ? 2 : (b ? 1 : 0);
    if (s) begin
      if (prio > 0 && (!m_pv || prio >= m_pprio)) begin
        m_pv = 1; m_pprio = prio; m_paddr = j ? jt : bt;
      end
    end else begin
      take = 1;
      tgt  = 0;
      if (j)         tgt = jt;
      else if (m_pv) tgt = m_paddr;
      else if (b)    tgt = bt;
      else           take = 0;
      m_pv = 0;
      if (take) begin
        m_pc  = align(tgt);
        m_red = 1;
        m_mis = (tgt % STEP) != 0;
      end else begin
        m_wrap = (m_pc + STEP) >= MOD;
        m_pc   = (m_pc + STEP) % MOD;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},          64'(pc),           64'(m_pc));
    check({tag, ".pc_next_seq"}, 64'(pc_next_seq),  (m_pc + STEP) % MOD);
    check({tag, ".pc_valid"},    64'(pc_valid),     64'(m_run));
    check({tag, ".redirect"},    64'(redirect),     64'(m_red));
    check({tag, ".misalign"},    64'(misalign_err), 64'(m_mis));
    check({tag, ".wrap"},        64'(wrap),         64'(m_wrap));
  endtask

  task automatic step(input string tag, input logic s, input logic j, input logic [31:0] jt,
                      input logic b, input logic [31:0] bt);
    stall = s; jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
    @(posedge clk);
    model_edge(s, j, 64'(jt), b, 64'(bt));
    #1;
    check_model(tag);
  endtask

  // Assert reset between edges, hold it across one edge, release mid-cycle.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_model({tag, ".async"});
    @(posedge clk);
    #1;
    check_model({tag, ".held"});
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        s, j;
    logic [31:0] jt;
    logic        b;
    logic [31:0] bt;
    logic [31:0] e_pc;
    logic        e_red, e_mis, e_wrap;
  } vec_t;

  function automatic vec_t vec(input logic s, input logic j, input logic [31:0] jt,
                               input logic b, input logic [31:0] bt, input logic [31:0] e_pc,
                               input logic e_red, input logic e_mis, input logic e_wrap);
    vec_t v;
    v.s = s; v.j = j; v.jt = jt; v.b = b; v.bt = bt;
    v.e_pc = e_pc; v.e_red = e_red; v.e_mis = e_mis; v.e_wrap = e_wrap;
    return v;
  endfunction

  vec_t vt[24];

  initial begin
    logic        rs, rj, rb;
    logic [31:0] rjt, rbt;

    rst = 1'b1; stall = 0; jump = 0; branch_taken = 0; jump_target = 0; branch_target = 0;
    s16 = 0; b16 = 0; j16 = 0; bt16 = 0; jt16 = 0;

    //           s  j  jt            b  bt            pc            red mis wrap
    vt[0]  = vec(0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0);
    vt[1]  = vec(0, 0, 32'h0,        0, 32'h0,        32'h4,        0, 0, 0);
    vt[2]  = vec(0, 0, 32'h0,        0, 32'h0,        32'h8,        0, 0, 0);
    vt[3]  = vec(0, 1, 32'h100,      0, 32'h0,        32'h100,      1, 0, 0);
    vt[4]  = vec(0, 1, 32'h200,      1, 32'h300,      32'h200,      1, 0, 0);
    vt[5]  = vec(0, 0, 32'h0,        0, 32'h0,        32'h204,      0, 0, 0);
    vt[6]  = vec(1, 0, 32'h0,        1, 32'h40,       32'h204,      0, 0, 0);
    vt[7]  = vec(1, 1, 32'h80,       0, 32'h0,        32'h204,      0, 0, 0);
    vt[8]  = vec(1, 0, 32'h0,        1, 32'h60,       32'h204,      0, 0, 0);
    vt[9]  = vec(0, 0, 32'h0,        0, 32'h0,        32'h80,       1, 0, 0);
    vt[10] = vec(0, 0, 32'h0,        0, 32'h0,        32'h84,       0, 0, 0);
    vt[11] = vec(0, 0, 32'h0,        1, 32'h106,      32'h104,      1, 1, 0);
    vt[12] = vec(0, 0, 32'h0,        0, 32'h0,        32'h108,      0, 0, 0);
    vt[13] = vec(1, 0, 32'h0,        1, 32'h30,       32'h108,      0, 0, 0);
    vt[14] = vec(1, 0, 32'h0,        1, 32'h50,       32'h108,      0, 0, 0);
    vt[15] = vec(0, 0, 32'h0,        1, 32'h70,       32'h50,       1, 0, 0);
    vt[16] = vec(1, 1, 32'h400,      0, 32'h0,        32'h50,       0, 0, 0);
    vt[17] = vec(0, 1, 32'h500,      0, 32'h0,        32'h500,      1, 0, 0);
    vt[18] = vec(0, 0, 32'h0,        0, 32'h0,        32'h504,      0, 0, 0);
    vt[19] = vec(1, 1, 32'h203,      0, 32'h0,        32'h504,      0, 0, 0);
    vt[20] = vec(0, 0, 32'h0,        0, 32'h0,        32'h200,      1, 1, 0);
    vt[21] = vec(0, 1, 32'hFFFFFFFC, 0, 32'h0,        32'hFFFFFFFC, 1, 0, 0);
    vt[22] = vec(0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 1);
    vt[23] = vec(0, 0, 32'h0,        0, 32'h0,        32'h4,        0, 0, 0);

    do_reset("reset0");
    check("reset0.pc_const", 64'(pc), 64'h0);

    for (int i = 0; i < 24; i++) begin
      step($sformatf("vec%0d", i), vt[i].s, vt[i].j, vt[i].jt, vt[i].b, vt[i].bt);
      check($sformatf("vec%0d.tbl_pc", i),  64'(pc),           64'(vt[i].e_pc));
      check($sformatf("vec%0d.tbl_red", i), 64'(redirect),     64'(vt[i].e_red));
      check($sformatf("vec%0d.tbl_mis", i), 64'(misalign_err), 64'(vt[i].e_mis));
      check($sformatf("vec%0d.tbl_wrp", i), 64'(wrap),         64'(vt[i].e_wrap));
    end

    // Reset while a branch is pending: pending dropped, BOOT ignores a jump.
    step("pend", 1, 0, 32'h0, 1, 32'h40);
    do_reset("reset1");
    check("reset1.pc_const", 64'(pc), 64'h0);
    step("boot", 0, 1, 32'h300, 0, 32'h0);
    check("boot.pc_const", 64'(pc), 64'h0);
    check("boot.valid_const", 64'(pc_valid), 64'h1);
    step("after_boot", 0, 0, 32'h0, 0, 32'h0);
    check("after_boot.pc_const", 64'(pc), 64'h4);

    // 16-bit / STEP=2 instance: misaligned jump to the top, then wrap.
    j16 = 1; jt16 = 16'hFFFF;
    step("w16a", 0, 0, 32'h0, 0, 32'h0);
    j16 = 0; jt16 = 16'h0;
    check("w16.pc_top",  64'(pc16),   64'hFFFE);
    check("w16.redir",   64'(red16),  64'h1);
    check("w16.mis",     64'(mis16),  64'h1);
    check("w16.nseq",    64'(nseq16), 64'h0);
    step("w16b", 0, 0, 32'h0, 0, 32'h0);
    check("w16.pc_zero", 64'(pc16),   64'h0);
    check("w16.wrap",    64'(wrap16), 64'h1);
    check("w16.noredir", 64'(red16),  64'h0);
    step("w16c", 0, 0, 32'h0, 0, 32'h0);
    check("w16.pc_two",  64'(pc16),   64'h2);
    check("w16.nowrap",  64'(wrap16), 64'h0);

    // Randomized traffic; targets biased toward the top of the space.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd_rst");
      rs  = ($urandom_range(0, 99) < 35);
      rj  = ($urandom_range(0, 99) < 15);
      rb  = ($urandom_range(0, 99) < 25);
      rjt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFF00 | 32'($urandom_range(0, 255))) : $urandom;
      rbt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFF00 | 32'($urandom_range(0, 255))) : $urandom;
      step("rnd", rs, rj, rjt, rb, rbt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
